psum_accumulator: RTL and testbench

Accumulates a configurable number of partial sums from the kernel adder into one output activation. It applies arithmetic right-shift requantization, optional ReLU and signed saturation, then emits the result on a valid/ready output bus to the output buffer writer. It sits directly downstream of the kernel signed adder, whose `OUT_WIDTH` result word is this block's input. A job is started by `cfg_start` and ends after `cfg_num_outputs` results have been written.

---
 rtl/psum_accumulator.sv | 148 ++++++++++++++
 tb/tb_psum_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates cfg_num_pass partial sums from the kernel adder into one
//   output activation, requantizes it (arithmetic right shift, optional ReLU,
//   signed saturation) and emits it on a valid/ready bus. A job started by
//   cfg_start produces cfg_num_outputs results, then pulses done.
//
// Ports:
//   clk, reset                        rising-edge clock, synchronous active-high reset
//   cfg_start                         start pulse, config sampled only when idle
//   cfg_num_pass/num_outputs/shift/relu  job configuration
//   ibus_valid/ibus_ready/ibus_data   partial-sum input bus (signed)
//   obus_valid/obus_ready/obus_data   result output bus (signed)
//   busy                              high while a job is active
//   done                              one-cycle pulse after the last result
module psum_accumulator #(
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned OUT_WIDTH      = 8,
  parameter int unsigned NUM_PASS_WIDTH = 8,
  parameter int unsigned NUM_OUT_WIDTH  = 16,
  parameter int unsigned SHIFT_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [NUM_PASS_WIDTH-1:0] cfg_num_pass,
  input  logic [NUM_OUT_WIDTH-1:0]  cfg_num_outputs,
  input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
  input  logic                      cfg_relu,
  input  logic                      ibus_valid,
  output logic                      ibus_ready,
  input  logic [IN_WIDTH-1:0]       ibus_data,
  output logic                      obus_valid,
  input  logic                      obus_ready,
  output logic [OUT_WIDTH-1:0]      obus_data,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  // Saturation bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                      state;
  logic [NUM_PASS_WIDTH-1:0]   num_pass;
  logic [NUM_PASS_WIDTH-1:0]   pass_cnt;
  logic [NUM_OUT_WIDTH-1:0]    num_outputs;
  logic [NUM_OUT_WIDTH-1:0]    out_cnt;
  logic [SHIFT_WIDTH-1:0]      shift;
  logic                        relu;
  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] clipped;
  logic [OUT_WIDTH-1:0]        quant;
  logic                        in_fire;
  logic                        out_fire;

  assign ibus_ready = (state == ACC);
  assign obus_valid = (state == OUT);
  assign busy       = (state != IDLE);
  assign in_fire    = ibus_valid && ibus_ready;
  assign out_fire   = obus_valid && obus_ready;

  // Requantization of acc + incoming data; only registered on the final pass.
  always_comb begin
    sum     = acc + {{(ACC_WIDTH-IN_WIDTH){ibus_data[IN_WIDTH-1]}}, ibus_data};
    shifted = sum >>> shift;
    clipped = shifted;
    if (relu && (shifted < 0)) begin
      clipped = '0;
    end
    if (clipped > SAT_MAX) begin
      quant = SAT_MAX[OUT_WIDTH-1:0];
    end else if (clipped < SAT_MIN) begin
      quant = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      quant = clipped[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      num_pass    <= '0;
      pass_cnt    <= '0;
      num_outputs <= '0;
      out_cnt     <= '0;
      shift       <= '0;
      relu        <= 1'b0;
      acc         <= '0;
      obus_data   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            // A pass count of zero is treated as a single pass.
            num_pass    <= (cfg_num_pass == '0) ? NUM_PASS_WIDTH'(1) : cfg_num_pass;
            num_outputs <= cfg_num_outputs;
            shift       <= cfg_shift;
            relu        <= cfg_relu;
            acc         <= '0;
            pass_cnt    <= '0;
            out_cnt     <= '0;
            if (cfg_num_outputs == '0) begin
              done <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (in_fire) begin
            if (pass_cnt == num_pass - NUM_PASS_WIDTH'(1)) begin
              obus_data <= quant;
              acc       <= '0;
              pass_cnt  <= '0;
              state     <= OUT;
            end else begin
              acc      <= sum;
              pass_cnt <= pass_cnt + NUM_PASS_WIDTH'(1);
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            out_cnt <= out_cnt + NUM_OUT_WIDTH'(1);
            if (out_cnt == num_outputs - NUM_OUT_WIDTH'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
//   Directed-vector bench for psum_accumulator with hand-computed results.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_psum_accumulator;

  logic        clk;
  logic        reset;
  logic        cfg_start;
  logic [7:0]  cfg_num_pass;
  logic [15:0] cfg_num_outputs;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        ibus_valid;
  logic        ibus_ready;
  logic [15:0] ibus_data;
  logic        obus_valid;
  logic        obus_ready;
  logic [7:0]  obus_data;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  psum_accumulator #(
    .IN_WIDTH       (16),
    .ACC_WIDTH      (32),
    .OUT_WIDTH      (8),
    .NUM_PASS_WIDTH (8),
    .NUM_OUT_WIDTH  (16),
    .SHIFT_WIDTH    (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_num_pass    (cfg_num_pass),
    .cfg_num_outputs (cfg_num_outputs),
    .cfg_shift       (cfg_shift),
    .cfg_relu        (cfg_relu),
    .ibus_valid      (ibus_valid),
    .ibus_ready      (ibus_ready),
    .ibus_data       (ibus_data),
    .obus_valid      (obus_valid),
    .obus_ready      (obus_ready),
    .obus_data       (obus_data),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int np, input int no, input int sh, input bit rl);
    cfg_num_pass    = 8'(np);
    cfg_num_outputs = 16'(no);
    cfg_shift       = 5'(sh);
    cfg_relu        = rl;
    cfg_start       = 1'b1;
    tick();
    cfg_start       = 1'b0;
  endtask

  task automatic send(input int d);
    int n = 0;
    ibus_valid = 1'b1;
    ibus_data  = 16'(d);
    while (!ibus_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    tick();
    ibus_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp, input bit last);
    int n = 0;
    while (!obus_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("out_timeout", 0, 1);
    chk(tag, $signed(obus_data), exp);
    obus_ready = 1'b1;
    tick();
    obus_ready = 1'b0;
    if (last) begin
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      tick();
      chk({tag, "_done_low"}, done, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0; cfg_num_pass = '0; cfg_num_outputs = '0;
    cfg_shift = '0; cfg_relu = 1'b0;
    ibus_valid = 1'b0; ibus_data = '0; obus_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_ibus_ready", ibus_ready, 0);
    chk("rst_obus_valid", obus_valid, 0);
    chk("rst_obus_data", obus_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Basic: 100+200-50 = 250, >>>2 = 62
    start_job(3, 1, 2, 0);
    chk("basic_busy", busy, 1);
    send(100); send(200); send(-50);
    chk("basic_latency", obus_valid, 1);
    expect_out("basic", 62, 1);

    // Positive saturation: 2000 -> 127
    start_job(2, 1, 0, 0);
    send(1000); send(1000);
    expect_out("sat_pos", 127, 1);

    // Negative saturation: -1000 -> -128
    start_job(2, 1, 0, 0);
    send(-1000); send(0);
    expect_out("sat_neg", -128, 1);

    // ReLU clamps the negative result
    start_job(2, 1, 0, 1);
    send(-1000); send(0);
    expect_out("relu", 0, 1);

    // Floor rounding: -5>>>1 = -3, 5>>>1 = 2
    start_job(1, 2, 1, 0);
    send(-5);
    expect_out("floor_neg", -3, 0);
    send(5);
    expect_out("floor_pos", 2, 1);

    // Backpressure: first result 10+20=30 held for 5 cycles with input offered
    start_job(2, 2, 0, 0);
    send(10); send(20);
    ibus_valid = 1'b1;
    ibus_data  = 16'(99);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", obus_valid, 1);
      chk("bp_data", $signed(obus_data), 30);
      chk("bp_ibus_ready", ibus_ready, 0);
      tick();
    end
    ibus_valid = 1'b0;
    expect_out("bp_first", 30, 0);
    send(3); send(4);
    expect_out("bp_second", 7, 1);

    // num_pass=0 acts as a single pass
    start_job(0, 1, 0, 0);
    send(7);
    expect_out("np_zero", 7, 1);

    // Zero outputs: done pulse only
    start_job(2, 0, 0, 0);
    chk("no_out_done", done, 1);
    chk("no_out_busy", busy, 0);
    chk("no_out_valid", obus_valid, 0);
    tick();
    chk("no_out_done_low", done, 0);

    // cfg_start mid-job must not relatch config: 5+6 = 11 at shift 0
    start_job(2, 1, 0, 0);
    send(5);
    cfg_start = 1'b1; cfg_num_outputs = 16'd0; cfg_num_pass = 8'd1; cfg_shift = 5'd3;
    send(6);
    cfg_start = 1'b0;
    expect_out("mid_start", 11, 1);

    // Reset mid-ACC after 2 of 4 inputs, then a clean job: 1+2+3+4 = 10
    start_job(4, 1, 0, 0);
    send(1); send(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_ibus_ready", ibus_ready, 0);
    chk("mrst_obus_valid", obus_valid, 0);
    chk("mrst_obus_data", obus_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    start_job(4, 1, 0, 0);
    send(1); send(2); send(3); send(4);
    expect_out("after_rst", 10, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
